// File: rtl/snake_game_ctrl_if.sv
// Snake datapath <-> game sequencer link: move requests, direction,
// grow pulses and the per-tick status the snake reports back.
interface snake_game_ctrl_if;
   logic       o_game_rst_n;
   logic       o_tick;
   logic [1:0] o_dir;
   logic       o_eat;
   logic [1:0] i_head_dir;
   logic       i_tick_interval;
   logic       i_tick_done;
   logic       i_failure;
   logic       i_success;
   logic       i_apple_hit;

   modport master (
      output o_game_rst_n,
      output o_tick,
      output o_dir,
      output o_eat,
      input  i_head_dir,
      input  i_tick_interval,
      input  i_tick_done,
      input  i_failure,
      input  i_success,
      input  i_apple_hit
   );

   modport slave (
      input  o_game_rst_n,
      input  o_tick,
      input  o_dir,
      input  o_eat,
      output i_head_dir,
      output i_tick_interval,
      output i_tick_done,
      output i_failure,
      output i_success,
      output i_apple_hit
   );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, frame-paced move ticks with speed-up,
// direction latch with reversal guard, eat pulses and saturating score.
module snake_game_ctrl #(
   parameter int unsigned BASE_PERIOD   = 8,
   parameter int unsigned MIN_PERIOD    = 2,
   parameter int unsigned SPEEDUP_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_frame,
   input  logic        i_btn_up,
   input  logic        i_btn_down,
   input  logic        i_btn_left,
   input  logic        i_btn_right,
   input  logic        i_btn_start,
   snake_game_ctrl_if.master snk,
   output logic [1:0]  o_state,
   output logic [7:0]  o_score
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DEAD = 2'b10,
      WIN  = 2'b11
   } state_e;

   state_e     state_q;
   logic       start_q;
   logic       tick_q;
   logic       eat_q;
   logic       hit_q;
   logic       grst_q;
   logic [1:0] dir_q;
   logic [7:0] score_q;
   logic [7:0] frame_q;

   logic       start_rise;
   logic [7:0] dec;
   logic [7:0] sub;
   logic [7:0] period;
   logic       elapse;
   logic       btn_any;
   logic [1:0] cand;
   logic       reversal;
   logic       fail_hit;

   localparam logic [7:0] BASE8 = 8'(BASE_PERIOD);
   localparam logic [7:0] MIN8  = 8'(MIN_PERIOD);

   assign start_rise = i_btn_start & ~start_q;
   assign fail_hit   = snk.i_failure & snk.i_tick_interval;

   // Period shrinks with score, saturating at zero before the floor clamp.
   always_comb begin
      dec    = score_q >> SPEEDUP_SHIFT;
      sub    = (dec >= BASE8) ? 8'd0 : BASE8 - dec;
      period = (sub < MIN8) ? MIN8 : sub;
      elapse = (frame_q >= period - 8'd1);
   end

   always_comb begin
      cand    = 2'b11;
      btn_any = 1'b1;
      priority case (1'b1)
         i_btn_up:    cand = 2'b00;
         i_btn_down:  cand = 2'b01;
         i_btn_left:  cand = 2'b10;
         i_btn_right: cand = 2'b11;
         default:     btn_any = 1'b0;
      endcase
      reversal = (cand[1] == snk.i_head_dir[1]) &&
                 (cand[0] != snk.i_head_dir[0]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         tick_q  <= 1'b0;
         eat_q   <= 1'b0;
         hit_q   <= 1'b0;
         grst_q  <= 1'b0;
         dir_q   <= 2'b11;
         score_q <= 8'd0;
         frame_q <= 8'd0;
      end else begin
         start_q <= i_btn_start;
         grst_q  <= (state_q != IDLE);
         eat_q   <= 1'b0;
         if (eat_q && score_q != 8'hFF)
            score_q <= score_q + 8'd1;

         unique case (state_q)
            IDLE: begin
               tick_q  <= 1'b0;
               frame_q <= 8'd0;
               if (start_rise) begin
                  state_q <= RUN;
                  score_q <= 8'd0;
                  dir_q   <= 2'b11;
                  hit_q   <= 1'b0;
                  eat_q   <= 1'b0;
               end
            end

            RUN: begin
               if (btn_any && !reversal)
                  dir_q <= cand;

               // A new period beats the ack clear; an unacked tick merges.
               if (snk.i_tick_interval)
                  tick_q <= 1'b0;
               if (i_frame) begin
                  if (elapse) begin
                     frame_q <= 8'd0;
                     tick_q  <= 1'b1;
                  end else begin
                     frame_q <= frame_q + 8'd1;
                  end
               end

               if (snk.i_apple_hit && snk.i_tick_interval)
                  hit_q <= 1'b1;
               if (snk.i_tick_done && hit_q) begin
                  eat_q <= 1'b1;
                  hit_q <= 1'b0;
               end

               if (fail_hit) begin
                  state_q <= DEAD;
                  tick_q  <= 1'b0;
                  frame_q <= 8'd0;
               end else if (snk.i_success) begin
                  state_q <= WIN;
                  tick_q  <= 1'b0;
                  frame_q <= 8'd0;
               end
            end

            DEAD, WIN: begin
               tick_q  <= 1'b0;
               frame_q <= 8'd0;
               if (start_rise)
                  state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign snk.o_game_rst_n = grst_q;
   assign snk.o_tick       = tick_q;
   assign snk.o_dir        = dir_q;
   assign snk.o_eat        = eat_q;
   assign o_state          = state_q;
   assign o_score          = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: FSM, pacing, direction, eat, score.
module tb_snake_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame = 1'b0;
   logic       up = 1'b0;
   logic       dn = 1'b0;
   logic       lf = 1'b0;
   logic       rt = 1'b0;
   logic       start = 1'b0;
   logic [1:0] state;
   logic [7:0] score;
   int         total = 0;
   int         bad = 0;

   snake_game_ctrl_if sif ();

   snake_game_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_frame     (frame),
      .i_btn_up    (up),
      .i_btn_down  (dn),
      .i_btn_left  (lf),
      .i_btn_right (rt),
      .i_btn_start (start),
      .snk         (sif),
      .o_state     (state),
      .o_score     (score)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int frames);
      frames = 0;
      while (frames < 40 && !sif.o_tick) begin
         frame = 1'b1;
         cyc();
         frame = 1'b0;
         cyc();
         frames++;
      end
      total++;
      if (sif.o_tick !== 1'b1) begin
         bad++;
         $display("FAIL tick_timeout got=%0b exp=1", sif.o_tick);
      end
   endtask

   task automatic ack_tick(input bit hit);
      sif.i_tick_interval = 1'b1;
      sif.i_apple_hit = hit;
      cyc();
      sif.i_apple_hit = 1'b0;
      sif.i_tick_interval = 1'b0;
      sif.i_tick_done = 1'b1;
      cyc();
      sif.i_tick_done = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      total++;
      if (state !== 2'b00 || sif.o_game_rst_n !== 1'b0 ||
          sif.o_dir !== 2'b11 || score !== 8'd0 ||
          sif.o_tick !== 1'b0 || sif.o_eat !== 1'b0) begin
         bad++;
         $display("FAIL reset got st=%0h gr=%0b dir=%0h sc=%0d tk=%0b eat=%0b exp 0 0 3 0 0 0",
                  state, sif.o_game_rst_n, sif.o_dir, score, sif.o_tick, sif.o_eat);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_start();
      start = 1'b1;
      cyc();
      total++;
      if (state !== 2'b01 || sif.o_game_rst_n !== 1'b0) begin
         bad++;
         $display("FAIL start_edge got st=%0h gr=%0b exp st=1 gr=0", state, sif.o_game_rst_n);
      end
      cyc();
      total++;
      if (sif.o_game_rst_n !== 1'b1 || sif.o_dir !== 2'b11) begin
         bad++;
         $display("FAIL start_grst got gr=%0b dir=%0h exp gr=1 dir=3", sif.o_game_rst_n, sif.o_dir);
      end
      start = 1'b0;
      cyc();
   endtask

   task automatic test_dir();
      sif.i_head_dir = 2'b11;
      lf = 1'b1;
      cyc();
      total++;
      if (sif.o_dir !== 2'b11) begin
         bad++;
         $display("FAIL dir_reverse got=%0h exp=3", sif.o_dir);
      end
      lf = 1'b0;
      up = 1'b1;
      cyc();
      total++;
      if (sif.o_dir !== 2'b00) begin
         bad++;
         $display("FAIL dir_up got=%0h exp=0", sif.o_dir);
      end
      rt = 1'b1;
      cyc();
      total++;
      if (sif.o_dir !== 2'b00) begin
         bad++;
         $display("FAIL dir_prio got=%0h exp=0", sif.o_dir);
      end
      up = 1'b0;
      rt = 1'b0;
      sif.i_head_dir = 2'b00;
      dn = 1'b1;
      cyc();
      total++;
      if (sif.o_dir !== 2'b00) begin
         bad++;
         $display("FAIL dir_down_rev got=%0h exp=0", sif.o_dir);
      end
      dn = 1'b0;
      lf = 1'b1;
      cyc();
      total++;
      if (sif.o_dir !== 2'b10) begin
         bad++;
         $display("FAIL dir_left got=%0h exp=2", sif.o_dir);
      end
      lf = 1'b0;
      cyc();
      total++;
      if (sif.o_dir !== 2'b10) begin
         bad++;
         $display("FAIL dir_hold got=%0h exp=2", sif.o_dir);
      end
   endtask

   task automatic test_tick();
      int f;
      int rises;
      logic prev;
      wait_tick(f);
      total++;
      if (f != 8) begin
         bad++;
         $display("FAIL first_period got=%0d exp=8", f);
      end
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++;
         if (sif.o_tick !== 1'b1) begin
            bad++;
            $display("FAIL tick_hold%0d got=%0b exp=1", i, sif.o_tick);
         end
      end
      sif.i_tick_interval = 1'b1;
      cyc();
      sif.i_tick_interval = 1'b0;
      total++;
      if (sif.o_tick !== 1'b0) begin
         bad++;
         $display("FAIL tick_drop got=%0b exp=0", sif.o_tick);
      end
      sif.i_tick_done = 1'b1;
      cyc();
      sif.i_tick_done = 1'b0;
      rises = 0;
      prev = sif.o_tick;
      for (int i = 0; i < 16; i++) begin
         frame = 1'b1;
         cyc();
         frame = 1'b0;
         if (sif.o_tick && !prev) rises++;
         prev = sif.o_tick;
         cyc();
      end
      total++;
      if (rises != 1 || sif.o_tick !== 1'b1) begin
         bad++;
         $display("FAIL tick_merge got rises=%0d tk=%0b exp rises=1 tk=1", rises, sif.o_tick);
      end
      sif.i_tick_interval = 1'b1;
      cyc();
      sif.i_tick_interval = 1'b0;
      cyc();
      cyc();
      cyc();
      total++;
      if (sif.o_tick !== 1'b0) begin
         bad++;
         $display("FAIL tick_no_queue got=%0b exp=0", sif.o_tick);
      end
   endtask

   task automatic test_eat();
      int f;
      int eats;
      wait_tick(f);
      sif.i_tick_interval = 1'b1;
      sif.i_apple_hit = 1'b1;
      cyc();
      sif.i_apple_hit = 1'b0;
      cyc();
      sif.i_apple_hit = 1'b1;
      cyc();
      sif.i_apple_hit = 1'b0;
      sif.i_tick_interval = 1'b0;
      sif.i_tick_done = 1'b1;
      cyc();
      sif.i_tick_done = 1'b0;
      total++;
      if (sif.o_eat !== 1'b1 || score !== 8'd0) begin
         bad++;
         $display("FAIL eat_pulse got eat=%0b sc=%0d exp eat=1 sc=0", sif.o_eat, score);
      end
      eats = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (sif.o_eat) eats++;
      end
      total++;
      if (eats != 0 || score !== 8'd1) begin
         bad++;
         $display("FAIL eat_once got extra=%0d sc=%0d exp extra=0 sc=1", eats, score);
      end
   endtask

   task automatic test_period();
      int f;
      logic [7:0] s;
      for (int i = 0; i < 40 && score < 8'd28; i++) begin
         s = score;
         wait_tick(f);
         ack_tick(1'b1);
         if (s == 8'd4) begin
            total++;
            if (f != 7) begin
               bad++;
               $display("FAIL period_s4 got=%0d exp=7", f);
            end
         end
         if (s == 8'd8) begin
            total++;
            if (f != 6) begin
               bad++;
               $display("FAIL period_s8 got=%0d exp=6", f);
            end
         end
         if (s == 8'd24) begin
            total++;
            if (f != 2) begin
               bad++;
               $display("FAIL period_s24 got=%0d exp=2", f);
            end
         end
      end
      total++;
      if (score !== 8'd28) begin
         bad++;
         $display("FAIL score28 got=%0d exp=28", score);
      end
   endtask

   task automatic test_end();
      int f;
      sif.i_failure = 1'b1;
      cyc();
      sif.i_failure = 1'b0;
      total++;
      if (state !== 2'b01) begin
         bad++;
         $display("FAIL fail_outside got=%0h exp=1", state);
      end
      wait_tick(f);
      total++;
      if (f != 2) begin
         bad++;
         $display("FAIL period_clamp got=%0d exp=2", f);
      end
      sif.i_tick_interval = 1'b1;
      sif.i_apple_hit = 1'b1;
      cyc();
      sif.i_apple_hit = 1'b0;
      sif.i_failure = 1'b1;
      sif.i_success = 1'b1;
      sif.i_tick_done = 1'b1;
      cyc();
      sif.i_tick_interval = 1'b0;
      sif.i_failure = 1'b0;
      sif.i_success = 1'b0;
      sif.i_tick_done = 1'b0;
      total++;
      if (state !== 2'b10 || sif.o_tick !== 1'b0 || sif.o_eat !== 1'b1) begin
         bad++;
         $display("FAIL dead got st=%0h tk=%0b eat=%0b exp st=2 tk=0 eat=1",
                  state, sif.o_tick, sif.o_eat);
      end
      cyc();
      total++;
      if (score !== 8'd29 || sif.o_eat !== 1'b0) begin
         bad++;
         $display("FAIL dead_eat got sc=%0d eat=%0b exp sc=29 eat=0", score, sif.o_eat);
      end
      start = 1'b1;
      cyc();
      total++;
      if (state !== 2'b00) begin
         bad++;
         $display("FAIL dead_to_idle got=%0h exp=0", state);
      end
      cyc();
      total++;
      if (state !== 2'b00 || sif.o_game_rst_n !== 1'b0) begin
         bad++;
         $display("FAIL idle_hold got st=%0h gr=%0b exp st=0 gr=0", state, sif.o_game_rst_n);
      end
      start = 1'b0;
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      total++;
      if (state !== 2'b01 || score !== 8'd0 || sif.o_dir !== 2'b11) begin
         bad++;
         $display("FAIL restart got st=%0h sc=%0d dir=%0h exp st=1 sc=0 dir=3",
                  state, score, sif.o_dir);
      end
   endtask

   task automatic test_win();
      sif.i_success = 1'b1;
      cyc();
      sif.i_success = 1'b0;
      total++;
      if (state !== 2'b11) begin
         bad++;
         $display("FAIL win got=%0h exp=3", state);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      total++;
      if (state !== 2'b00) begin
         bad++;
         $display("FAIL win_to_idle got=%0h exp=0", state);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
   endtask

   task automatic test_saturate();
      int f;
      for (int i = 0; i < 300 && score != 8'd255; i++) begin
         wait_tick(f);
         ack_tick(1'b1);
      end
      wait_tick(f);
      ack_tick(1'b1);
      total++;
      if (score !== 8'd255) begin
         bad++;
         $display("FAIL score_sat got=%0d exp=255", score);
      end
   endtask

   task automatic test_rst_mid();
      rst_n = 1'b0;
      cyc();
      total++;
      if (state !== 2'b00 || score !== 8'd0 || sif.o_game_rst_n !== 1'b0 ||
          sif.o_tick !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid got st=%0h sc=%0d gr=%0b tk=%0b exp 0 0 0 0",
                  state, score, sif.o_game_rst_n, sif.o_tick);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      sif.i_head_dir = 2'b11;
      sif.i_tick_interval = 1'b0;
      sif.i_tick_done = 1'b0;
      sif.i_failure = 1'b0;
      sif.i_success = 1'b0;
      sif.i_apple_hit = 1'b0;
      test_reset();
      test_start();
      test_dir();
      test_tick();
      test_eat();
      test_period();
      test_end();
      test_win();
      test_saturate();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Top-level game sequencer for the snake datapath.
- Owns the game state machine (IDLE/RUN/DEAD/WIN) and holds the snake in reset while idle.
- Paces movement ticks from the video frame strobe, with a speed-up as the score grows.
- Latches player direction and rejects 180-degree reversals.
- Converts apple hits into single-cycle eat pulses and keeps the score.

Parameters:
BASE_PERIOD, 8, frames per move tick at score 0 (4-bit, 2..15)
MIN_PERIOD, 2, lower clamp on frames per tick (1..BASE_PERIOD)
SPEEDUP_SHIFT, 2, period shrinks by 1 per 2^SPEEDUP_SHIFT points

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
i_frame  in  1  one-cycle pulse per video frame
i_btn_up / i_btn_down / i_btn_left / i_btn_right  in  1 each  debounced button levels
i_btn_start  in  1  debounced start level
i_head_dir  in  2  current snake head direction
i_tick_interval  in  1  snake is walking its body after a tick
i_tick_done  in  1  one-cycle end-of-walk strobe from snake
i_failure  in  1  snake collision indication
i_success  in  1  snake at maximum length
i_apple_hit  in  1  apple comparator match; valid only while i_tick_interval=1
o_game_rst_n  out  1  active-low reset to snake and apple logic
o_tick  out  1  move request to snake (level)
o_dir  out  2  direction for the next move
o_eat  out  1  one-cycle grow pulse to snake
o_state  out  2  00 IDLE, 01 RUN, 10 DEAD, 11 WIN
o_score  out  8  apples eaten, saturating

Behaviour:
Reset and outputs:
- Reset values: state=IDLE, o_tick=0, o_eat=0, o_dir=2'b11, o_score=0, frame_cnt=0, start_q=0, all flags=0.
- o_game_rst_n = (state==RUN || state==DEAD || state==WIN), registered; it is 0 during IDLE and during rst_n.
- Direction encoding: 00 up (y-1), 01 down, 10 left, 11 right.

Start edge (start_rise = i_btn_start && !start_q, start_q registered every cycle):
- IDLE->RUN on start_rise; clears score, frame_cnt, o_dir<=11 and all flags in the same edge.
- DEAD->IDLE and WIN->IDLE on start_rise.
- In RUN, start is ignored.

Direction latch, RUN only, every cycle:
- Candidate priority: up > down > left > right.
- Rejected if candidate[1]==i_head_dir[1] && candidate[0]!=i_head_dir[0] (reversal).
- Otherwise o_dir<=candidate.
- No button pressed: o_dir holds.
- o_dir updates freely while o_tick is high; the snake samples it when it takes the tick.

Tick pacing:
- period = max(MIN_PERIOD, BASE_PERIOD - (o_score>>SPEEDUP_SHIFT)), computed with 8-bit saturating subtract.
- In RUN, on i_frame: if frame_cnt >= period-1 then frame_cnt<=0 and o_tick<=1; else frame_cnt++.
- o_tick clears on the cycle after i_tick_interval is sampled 1.
- A period elapsing while o_tick is still 1 does not queue a second tick (merged).
- Outside RUN: o_tick=0 and frame_cnt holds 0.

Eat:
- hit_flag sets when i_apple_hit && i_tick_interval in RUN.
- o_eat=1 for exactly the one cycle after i_tick_done && hit_flag; hit_flag clears on that same edge.
- o_score increments on o_eat, saturating at 255.
- At most one eat per tick.

End of game:
- In RUN, i_failure && i_tick_interval -> DEAD next cycle.
- Else i_success -> WIN next cycle; failure has priority when both are true.
- On entering DEAD/WIN: o_tick<=0; a pending o_eat still fires and the score still counts it.
- i_failure outside a tick interval is ignored, since body positions are invalid then.

rst_n low mid-game: returns to IDLE on the next edge, all registers take reset values and o_game_rst_n=0.

Test Plan:
- Reset then start_rise -> o_state 00->01 and o_game_rst_n 0->1 one cycle later; o_dir=11; first o_tick after 8 i_frame pulses.
- RUN with i_head_dir=11, press left -> o_dir stays 11; press up -> o_dir=00; press up+right together -> o_dir=00.
- o_tick asserted, i_tick_interval delayed 5 cycles -> o_tick held high 5 cycles, drops the cycle after interval=1; 16 frames without ack -> only one tick delivered.
- i_apple_hit pulsed twice in one interval, then i_tick_done -> exactly one o_eat pulse one cycle later; o_score 0->1.
- Score forced to 4 -> period 7 frames; score 24 -> period clamps to 2.
- i_failure && i_tick_interval together with i_success -> o_state=10 next cycle, o_tick=0; start_rise -> IDLE; rst_n low mid-RUN -> IDLE with o_score=0.
